// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: state codes, opcode constants/masks, ALU codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package legv8_pkg;

   localparam int OPC_BITS = 11;

   // State codes are visible on the debug 'state' port, so they are fixed here.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_WB_R   = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_WB_MEM = 4'd7,
      S_MEM_WR = 4'd8,
      S_BR_CBZ = 4'd9,
      S_BR_B   = 4'd10,
      S_ERROR  = 4'd15
   } state_e;

   // Opcode values (IR[31:21]) and the masks selecting the bits that matter.
   localparam logic [OPC_BITS-1:0] OPC_ADD   = 11'b10001011000;
   localparam logic [OPC_BITS-1:0] OPC_SUB   = 11'b11001011000;
   localparam logic [OPC_BITS-1:0] OPC_AND   = 11'b10001010000;
   localparam logic [OPC_BITS-1:0] OPC_ORR   = 11'b10101010000;
   localparam logic [OPC_BITS-1:0] OPC_LDUR  = 11'b11111000010;
   localparam logic [OPC_BITS-1:0] OPC_STUR  = 11'b11111000000;
   localparam logic [OPC_BITS-1:0] OPC_CBZ   = 11'b10110100000;
   localparam logic [OPC_BITS-1:0] OPC_B     = 11'b00010100000;

   localparam logic [OPC_BITS-1:0] MASK_FULL = 11'b11111111111;
   localparam logic [OPC_BITS-1:0] MASK_CBZ  = 11'b11111111000;
   localparam logic [OPC_BITS-1:0] MASK_B    = 11'b11111100000;

   // alu_op codes
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // alu_src_b codes
   localparam logic [1:0] SRCB_RM       = 2'd0;
   localparam logic [1:0] SRCB_FOUR     = 2'd1;
   localparam logic [1:0] SRCB_SEXT     = 2'd2;
   localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

   // pc_source codes
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_BRANCH = 2'd1;

   // ALU operation codes produced by alu_ctrl for the ALU block.
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   // Instruction class resolved in DECODE.
   typedef enum logic [2:0] {
      CLS_NOP = 3'd0,
      CLS_R   = 3'd1,
      CLS_MEM = 3'd2,
      CLS_CBZ = 3'd3,
      CLS_B   = 3'd4
   } ins_cls_e;

   // Every datapath select/enable driven by the FSM, one bundle.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg2loc;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

   function automatic logic opc_match(input logic [OPC_BITS-1:0] opc,
                                      input logic [OPC_BITS-1:0] val,
                                      input logic [OPC_BITS-1:0] mask);
      return ((opc ^ val) & mask) == '0;
   endfunction

   function automatic ins_cls_e classify(input logic [OPC_BITS-1:0] opc);
      ins_cls_e cls;
      cls = CLS_NOP;
      if (opc_match(opc, OPC_ADD, MASK_FULL) || opc_match(opc, OPC_SUB, MASK_FULL) ||
          opc_match(opc, OPC_AND, MASK_FULL) || opc_match(opc, OPC_ORR, MASK_FULL))
         cls = CLS_R;
      else if (opc_match(opc, OPC_LDUR, MASK_FULL) || opc_match(opc, OPC_STUR, MASK_FULL))
         cls = CLS_MEM;
      else if (opc_match(opc, OPC_CBZ, MASK_CBZ))
         cls = CLS_CBZ;
      else if (opc_match(opc, OPC_B, MASK_B))
         cls = CLS_B;
      return cls;
   endfunction

   // ALU control: alu_op from the FSM plus the opcode for R-type funct decode.
   function automatic logic [3:0] alu_ctrl(input logic [1:0] alu_op,
                                           input logic [OPC_BITS-1:0] opc);
      logic [3:0] op;
      op = ALU_ADD;
      case (alu_op)
         ALUOP_ADD:   op = ALU_ADD;
         ALUOP_PASSB: op = ALU_PASSB;
         ALUOP_FUNCT: begin
            if (opc_match(opc, OPC_SUB, MASK_FULL))      op = ALU_SUB;
            else if (opc_match(opc, OPC_AND, MASK_FULL)) op = ALU_AND;
            else if (opc_match(opc, OPC_ORR, MASK_FULL)) op = ALU_ORR;
            else                                         op = ALU_ADD;
         end
         default:     op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory-wait watchdog: counts stalled cycles and flags the one that reaches TIMEOUT.
// Latency: hit is combinational on the current count and cnt_en.
// Backpressure: none; clr has priority over counting.
// Ports: clk, reset (async active-low), clr (restart count), cnt_en (stalled this
//        cycle), hit (this stalled cycle is the TIMEOUT-th one).
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic cnt_en,
   output logic hit
);

   // Count holds stalled cycles already seen; it never needs to exceed TIMEOUT-1.
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;

   assign hit = cnt_en && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (cnt_en && !hit) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM sequencing a multi-cycle LEGv8 datapath with a unified memory.
// Latency: R 4, LDUR 5, STUR 4, CBZ/B 3 cycles with zero-wait memory; NOP 2.
// Backpressure: mem_ready stalls FETCH/MEM_RD/MEM_WR; a TIMEOUT-long stall parks in ERROR.
// Ports: clk, reset (async active-low), run, opcode (IR[31:21]), zero, mem_ready;
//        datapath controls pc_write..alu_op, error (sticky), state (debug), instr_count.
module multicycle_control_fsm
   import legv8_pkg::*;
#(
   parameter int OPC_W   = 11,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             reg2loc,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             error,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   state_e     state_q;
   state_e     state_nxt;
   ctrl_t      ctrl;
   ins_cls_e   cls;
   logic       wait_st;
   logic       to_clr;
   logic       to_en;
   logic       to_hit;
   logic       retire;

   // zero only qualifies the PC load inside the datapath (via pc_write_cond);
   // the FSM never branches on it.
   logic unused_zero;
   assign unused_zero = zero;

   assign cls = classify(opcode);

   //---------------------------------------------------------------------------
   // Memory watchdog. Any state change restarts the count, which covers every
   // entry into a waiting state; only waiting states with mem_ready low count.
   //---------------------------------------------------------------------------
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   assign to_en   = wait_st && !mem_ready;
   assign to_clr  = (state_nxt != state_q);

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (to_clr),
      .cnt_en (to_en),
      .hit    (to_hit)
   );

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next state. mem_ready is tested before the watchdog so a completion in the
   // same cycle the stall limit is reached still finishes the access.
   //---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (run) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (mem_ready)   state_nxt = S_DECODE;
            else if (to_hit) state_nxt = S_ERROR;
         end
         S_DECODE: begin
            case (cls)
               CLS_R:   state_nxt = S_EXEC_R;
               CLS_MEM: state_nxt = S_ADDR;
               CLS_CBZ: state_nxt = S_BR_CBZ;
               CLS_B:   state_nxt = S_BR_B;
               default: state_nxt = S_FETCH;
            endcase
         end
         S_EXEC_R: state_nxt = S_WB_R;
         S_WB_R:   state_nxt = S_FETCH;
         S_ADDR: begin
            // Only LDUR/STUR reach ADDR, so anything other than LDUR is a store.
            if (opc_match(opcode, OPC_LDUR, MASK_FULL)) state_nxt = S_MEM_RD;
            else                                        state_nxt = S_MEM_WR;
         end
         S_MEM_RD: begin
            if (mem_ready)   state_nxt = S_WB_MEM;
            else if (to_hit) state_nxt = S_ERROR;
         end
         S_WB_MEM: state_nxt = S_FETCH;
         S_MEM_WR: begin
            if (mem_ready)   state_nxt = S_FETCH;
            else if (to_hit) state_nxt = S_ERROR;
         end
         S_BR_CBZ: state_nxt = S_FETCH;
         S_BR_B:   state_nxt = S_FETCH;
         S_ERROR:  state_nxt = S_ERROR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Output decode from the state register. The only input term is mem_ready
   // in FETCH: IR/PC must load exactly in the cycle the fetch data returns.
   //---------------------------------------------------------------------------
   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.i_or_d    = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Branch target is computed speculatively while the opcode decodes.
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_SEXT_SH2;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RM;
            ctrl.alu_op    = ALUOP_FUNCT;
            ctrl.reg2loc   = 1'b0;
         end
         S_WB_R: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.reg2loc   = 1'b1;
         end
         S_MEM_RD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            // Rt is read through port 2 as the store data.
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            ctrl.reg2loc   = 1'b1;
         end
         S_BR_CBZ: begin
            ctrl.reg2loc       = 1'b1;
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RM;
            ctrl.alu_op        = ALUOP_PASSB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_BRANCH;
         end
         S_BR_B: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_BRANCH;
         end
         default: ctrl = '0;
      endcase
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_source     = ctrl.pc_source;
   assign ir_write      = ctrl.ir_write;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign reg2loc       = ctrl.reg2loc;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign error         = (state_q == S_ERROR);
   assign state         = state_q;

   //---------------------------------------------------------------------------
   // Retired-instruction counter: bumps on the final cycle of a legal
   // instruction. DECODE->FETCH (NOP) is deliberately excluded.
   //---------------------------------------------------------------------------
   assign retire = (state_nxt == S_FETCH) &&
                   (state_q inside {S_WB_R, S_WB_MEM, S_MEM_WR, S_BR_CBZ, S_BR_B});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_count <= '0;
      end else if (retire) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_control_fsm;
   import legv8_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [10:0] opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
   logic        mem_to_reg, reg_write, reg2loc, alu_src_a, error;
   logic [1:0]  pc_source, alu_src_b, alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.OPC_W(11), .TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .reg2loc(reg2loc), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .error(error), .state(state),
      .instr_count(instr_count)
   );

   // Opcodes as seen in IR[31:21]
   localparam logic [10:0] T_ADD  = 11'b10001011000;
   localparam logic [10:0] T_SUB  = 11'b11001011000;
   localparam logic [10:0] T_AND  = 11'b10001010000;
   localparam logic [10:0] T_ORR  = 11'b10101010000;
   localparam logic [10:0] T_LDUR = 11'b11111000010;
   localparam logic [10:0] T_STUR = 11'b11111000000;
   localparam logic [10:0] T_CBZ  = 11'b10110100000;
   localparam logic [10:0] T_CBZ2 = 11'b10110100101;
   localparam logic [10:0] T_B    = 11'b00010110110;
   localparam logic [10:0] T_NOP  = 11'b11111111111;
   localparam logic [10:0] T_NEAR = 11'b11111000001;

   // Expected control word, field order:
   // pc_write pc_write_cond pc_source[2] ir_write i_or_d mem_read mem_write
   // mem_to_reg reg_write reg2loc alu_src_a alu_src_b[2] alu_op[2] error
   localparam logic [16:0] C_IDLE      = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_FETCH     = 17'b0_0_00_0_0_1_0_0_0_0_0_01_00_0;
   localparam logic [16:0] C_FETCH_RDY = 17'b1_0_00_1_0_1_0_0_0_0_0_01_00_0;
   localparam logic [16:0] C_DECODE    = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
   localparam logic [16:0] C_EXEC_R    = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [16:0] C_WB_R      = 17'b0_0_00_0_0_0_0_0_1_0_0_00_00_0;
   localparam logic [16:0] C_ADDR      = 17'b0_0_00_0_0_0_0_0_0_1_1_10_00_0;
   localparam logic [16:0] C_MEM_RD    = 17'b0_0_00_0_1_1_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_WB_MEM    = 17'b0_0_00_0_0_0_0_1_1_0_0_00_00_0;
   localparam logic [16:0] C_MEM_WR    = 17'b0_0_00_0_1_0_1_0_0_1_0_00_00_0;
   localparam logic [16:0] C_BR_CBZ    = 17'b0_1_01_0_0_0_0_0_0_1_1_00_01_0;
   localparam logic [16:0] C_BR_B      = 17'b1_0_01_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_ERROR     = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_1;

   typedef struct {
      logic        run;
      logic [10:0] opc;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [16:0] cw;
      logic [31:0] cnt;
   } vec_t;

   vec_t vq[$];

   function automatic logic [16:0] dut_cw();
      return {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
              mem_write, mem_to_reg, reg_write, reg2loc, alu_src_a, alu_src_b,
              alu_op, error};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic [10:0] o, input logic z, input logic rd,
                      input logic [3:0] s, input logic [16:0] c, input logic [31:0] n);
      vec_t v;
      v.run = r; v.opc = o; v.zero = z; v.rdy = rd; v.st = s; v.cw = c; v.cnt = n;
      vq.push_back(v);
   endtask

   // Advance one clock, then check the state in the low phase.
   task automatic step(input logic [3:0] s, input string nm);
      @(negedge clk); #1;
      chk(nm, {28'd0, state}, {28'd0, s});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("rst_cw", {15'd0, dut_cw()}, {15'd0, C_IDLE});
      chk("rst_cnt", instr_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; run = 1'b1; opcode = T_ADD; zero = 1'b0; mem_ready = 1'b1;

      // ---- Program table: one row per clock, starting right after reset release
      add(1, T_ADD,  0, 1, S_IDLE,   C_IDLE,      0);
      add(1, T_ADD,  0, 1, S_FETCH,  C_FETCH_RDY, 0);
      add(1, T_ADD,  0, 0, S_DECODE, C_DECODE,    0);
      add(1, T_ADD,  0, 1, S_EXEC_R, C_EXEC_R,    0);
      add(1, T_ADD,  0, 0, S_WB_R,   C_WB_R,      0);
      add(1, T_LDUR, 0, 1, S_FETCH,  C_FETCH_RDY, 1);
      add(1, T_LDUR, 0, 0, S_DECODE, C_DECODE,    1);
      add(1, T_LDUR, 0, 1, S_ADDR,   C_ADDR,      1);
      add(1, T_LDUR, 0, 0, S_MEM_RD, C_MEM_RD,    1);
      add(1, T_LDUR, 0, 0, S_MEM_RD, C_MEM_RD,    1);
      add(1, T_LDUR, 0, 0, S_MEM_RD, C_MEM_RD,    1);
      add(1, T_LDUR, 0, 1, S_MEM_RD, C_MEM_RD,    1);
      add(1, T_LDUR, 0, 1, S_WB_MEM, C_WB_MEM,    1);
      add(1, T_STUR, 0, 1, S_FETCH,  C_FETCH_RDY, 2);
      add(1, T_STUR, 0, 1, S_DECODE, C_DECODE,    2);
      add(1, T_STUR, 0, 0, S_ADDR,   C_ADDR,      2);
      add(1, T_STUR, 0, 1, S_MEM_WR, C_MEM_WR,    2);
      add(1, T_CBZ,  1, 1, S_FETCH,  C_FETCH_RDY, 3);
      add(1, T_CBZ,  1, 1, S_DECODE, C_DECODE,    3);
      add(1, T_CBZ,  1, 1, S_BR_CBZ, C_BR_CBZ,    3);
      add(1, T_CBZ,  0, 1, S_FETCH,  C_FETCH_RDY, 4);
      add(1, T_CBZ,  0, 0, S_DECODE, C_DECODE,    4);
      add(1, T_CBZ,  0, 0, S_BR_CBZ, C_BR_CBZ,    4);
      add(1, T_B,    0, 1, S_FETCH,  C_FETCH_RDY, 5);
      add(1, T_B,    0, 1, S_DECODE, C_DECODE,    5);
      add(1, T_B,    0, 1, S_BR_B,   C_BR_B,      5);
      add(1, T_NOP,  0, 1, S_FETCH,  C_FETCH_RDY, 6);
      add(1, T_NOP,  0, 1, S_DECODE, C_DECODE,    6);
      add(1, T_SUB,  0, 1, S_FETCH,  C_FETCH_RDY, 6);
      add(1, T_SUB,  0, 1, S_DECODE, C_DECODE,    6);
      add(1, T_SUB,  0, 1, S_EXEC_R, C_EXEC_R,    6);
      add(1, T_SUB,  0, 1, S_WB_R,   C_WB_R,      6);
      add(1, T_AND,  0, 1, S_FETCH,  C_FETCH_RDY, 7);
      add(1, T_AND,  0, 1, S_DECODE, C_DECODE,    7);
      add(1, T_AND,  0, 1, S_EXEC_R, C_EXEC_R,    7);
      add(1, T_AND,  0, 1, S_WB_R,   C_WB_R,      7);
      add(1, T_ORR,  0, 1, S_FETCH,  C_FETCH_RDY, 8);
      add(1, T_ORR,  0, 1, S_DECODE, C_DECODE,    8);
      add(1, T_ORR,  0, 1, S_EXEC_R, C_EXEC_R,    8);
      add(1, T_ORR,  0, 1, S_WB_R,   C_WB_R,      8);
      add(1, T_CBZ2, 0, 1, S_FETCH,  C_FETCH_RDY, 9);
      add(1, T_CBZ2, 0, 1, S_DECODE, C_DECODE,    9);
      add(1, T_CBZ2, 0, 1, S_BR_CBZ, C_BR_CBZ,    9);
      add(1, T_NEAR, 0, 1, S_FETCH,  C_FETCH_RDY, 10);
      add(1, T_NEAR, 0, 1, S_DECODE, C_DECODE,    10);
      add(1, T_ADD,  0, 0, S_FETCH,  C_FETCH,     10);

      // ---- Reset held with run=1: everything quiet
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("init_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("init_cw", {15'd0, dut_cw()}, {15'd0, C_IDLE});
      chk("init_cnt", instr_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---- Table run
      for (int i = 0; i < vq.size(); i++) begin
         run = vq[i].run; opcode = vq[i].opc; zero = vq[i].zero; mem_ready = vq[i].rdy;
         #1;
         chk($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vq[i].st});
         chk($sformatf("vec%0d_cw", i), {15'd0, dut_cw()}, {15'd0, vq[i].cw});
         chk($sformatf("vec%0d_cnt", i), instr_count, vq[i].cnt);
         @(negedge clk);
      end

      // ---- FETCH stall of 16 cycles ends in ERROR, which only reset leaves
      do_reset();
      run = 1'b1; mem_ready = 1'b0; opcode = T_ADD;
      for (int i = 1; i <= 16; i++) step(S_FETCH, $sformatf("fto_wait%0d", i));
      chk("fto_no_err_c16", {31'd0, error}, 32'd0);
      step(S_ERROR, "fto_err_state");
      chk("fto_err_cw", {15'd0, dut_cw()}, {15'd0, C_ERROR});
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) step(S_ERROR, "err_sticky");
      #2 reset = 1'b0;
      #1;
      chk("err_async_rst_state", {28'd0, state}, {28'd0, S_IDLE});
      chk("err_async_rst_err", {31'd0, error}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // ---- run=0 holds IDLE; ready on the 16th FETCH cycle wins over timeout
      run = 1'b0;
      step(S_IDLE, "idle_hold0");
      step(S_IDLE, "idle_hold1");
      run = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) step(S_FETCH, $sformatf("frdy_wait%0d", i));
      mem_ready = 1'b1;
      #1;
      chk("frdy_c16_cw", {15'd0, dut_cw()}, {15'd0, C_FETCH_RDY});
      step(S_DECODE, "frdy_decode");
      chk("frdy_no_err", {31'd0, error}, 32'd0);

      // ---- MEM_WR stall of 16 cycles ends in ERROR
      do_reset();
      run = 1'b1; mem_ready = 1'b1; opcode = T_STUR;
      step(S_FETCH, "wto_fetch");
      step(S_DECODE, "wto_decode");
      step(S_ADDR, "wto_addr");
      mem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) step(S_MEM_WR, $sformatf("wto_wait%0d", i));
      chk("wto_c16_mem_write", {31'd0, mem_write}, 32'd1);
      step(S_ERROR, "wto_err_state");
      chk("wto_err_flag", {31'd0, error}, 32'd1);

      // ---- Reset mid-read drops the request at once
      do_reset();
      run = 1'b1; mem_ready = 1'b1; opcode = T_LDUR;
      step(S_FETCH, "rrst_fetch");
      step(S_DECODE, "rrst_decode");
      step(S_ADDR, "rrst_addr");
      mem_ready = 1'b0;
      step(S_MEM_RD, "rrst_memrd");
      chk("rrst_mem_read_before", {31'd0, mem_read}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rrst_mem_read_dropped", {31'd0, mem_read}, 32'd0);
      chk("rrst_i_or_d_dropped", {31'd0, i_or_d}, 32'd0);
      chk("rrst_state", {28'd0, state}, {28'd0, S_IDLE});
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      step(S_FETCH, "rrst_refetch");
      chk("rrst_refetch_cw", {15'd0, dut_cw()}, {15'd0, C_FETCH_RDY});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
